lut_prog: RTL and testbench

Programmable, registered look-up table. It generalises the fixed 4-input single-output combinational LUT in three ways: parametrised input and output width, a truth table that is loaded at runtime through a serial configuration port, and a registered output with a valid flag. It sits between datapath logic and downstream registers wherever a truth-table function must be changed without resynthesis.

---
 rtl/lut_prog.sv | 111 +++++++++++
 tb/tb_lut_prog.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_prog.sv
// lut_prog: registered look-up table whose contents are reloaded through a serial config port.
// Optional macro LUT_READBACK_EN adds cfg_bit_o, a serial readback of the previous table during a load.
`default_nettype none

module lut_prog #(
  parameter int                          IN_W  = 4,
  parameter int                          OUT_W = 1,
  parameter logic [(2**IN_W)*OUT_W-1:0]  INIT  = 16'h0510
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IN_W-1:0]   x_i,
  input  logic              x_valid_i,
  output logic [OUT_W-1:0]  y_o,
  output logic              y_valid_o,
  input  logic              cfg_start_i,
  input  logic              cfg_bit_i,
  input  logic              cfg_valid_i,
  output logic              cfg_busy_o,
  output logic              cfg_done_o
`ifdef LUT_READBACK_EN
  ,
  output logic              cfg_bit_o
`endif
);

  localparam int DEPTH = 2**IN_W;
  localparam int NBITS = DEPTH * OUT_W;
  localparam int CNT_W = $clog2(NBITS) + 1;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [NBITS-1:0]   r_active;
  logic [NBITS-1:0]   r_shadow;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_y;
  logic               r_y_valid;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic [NBITS-1:0]   w_mask;
  logic [NBITS-1:0]   w_shadow_nxt;
  logic [OUT_W-1:0]   w_entry;
  logic               w_lookup;

  // A restart in the same cycle as a data bit wins; the bit is dropped.
  assign w_accept     = (r_state == S_LOAD) && cfg_valid_i && !cfg_start_i;
  assign w_last       = w_accept && (r_cnt == CNT_W'(NBITS - 1));
  assign w_mask       = {{(NBITS-1){1'b0}}, 1'b1} << r_cnt;
  assign w_shadow_nxt = cfg_bit_i ? (r_shadow | w_mask) : r_shadow;
  assign w_entry      = OUT_W'(r_active >> (int'(x_i) * OUT_W));
  assign w_lookup     = (r_state == S_RUN) && x_valid_i;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (cfg_start_i) w_state_next = S_LOAD;
      S_LOAD:  if (w_last)      w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_RUN;
      r_active  <= INIT;
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_y_valid <= w_lookup;
      r_done    <= w_last;
      if (w_lookup) r_y <= w_entry;
      if (cfg_start_i) begin
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (w_accept) begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_shadow <= w_shadow_nxt;
      end
      // Final bit goes straight into the active table so the first RUN cycle already sees it.
      if (w_last) r_active <= w_shadow_nxt;
    end
  end

  assign y_o        = r_y;
  assign y_valid_o  = r_y_valid;
  assign cfg_busy_o = (r_state == S_LOAD);
  assign cfg_done_o = r_done;

`ifdef LUT_READBACK_EN
  logic r_rb;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rb <= 1'b0;
    else       r_rb <= w_accept ? |(r_active & w_mask) : 1'b0;
  end
  assign cfg_bit_o = r_rb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_prog.sv
// tb_lut_prog: two lut_prog instances (default 4x1 and 2x3) against a behavioural table model.
`timescale 1ns/1ps
`default_nettype none

module tb_lut_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] x  [2];
  logic       xv [2];
  logic       cs [2];
  logic       cb [2];
  logic       cv [2];
  logic [1:0] xb;
  logic       ya;
  logic [2:0] yb;
  logic       yv_a, yv_b, busy_a, busy_b, done_a, done_b;
  logic       yv [2];
  logic       busy [2];
  logic       done [2];
  logic       rb [2];

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  assign xb = x[1][1:0];
  assign yv[0] = yv_a;     assign yv[1] = yv_b;
  assign busy[0] = busy_a; assign busy[1] = busy_b;
  assign done[0] = done_a; assign done[1] = done_b;

`ifdef LUT_READBACK_EN
  logic rb_a, rb_b;
  assign rb[0] = rb_a; assign rb[1] = rb_b;
`else
  assign rb[0] = 1'b0; assign rb[1] = 1'b0;
`endif

  lut_prog u_a (
    .clk_i(clk), .rst_i(rst), .x_i(x[0]), .x_valid_i(xv[0]),
    .y_o(ya), .y_valid_o(yv_a),
    .cfg_start_i(cs[0]), .cfg_bit_i(cb[0]), .cfg_valid_i(cv[0]),
    .cfg_busy_o(busy_a), .cfg_done_o(done_a)
`ifdef LUT_READBACK_EN
    , .cfg_bit_o(rb_a)
`endif
  );

  lut_prog #(.IN_W(2), .OUT_W(3), .INIT(12'h000)) u_b (
    .clk_i(clk), .rst_i(rst), .x_i(xb), .x_valid_i(xv[1]),
    .y_o(yb), .y_valid_o(yv_b),
    .cfg_start_i(cs[1]), .cfg_bit_i(cb[1]), .cfg_valid_i(cv[1]),
    .cfg_busy_o(busy_b), .cfg_done_o(done_b)
`ifdef LUT_READBACK_EN
    , .cfg_bit_o(rb_b)
`endif
  );

  // ---------------- behavioural model ----------------
  function automatic int nb(input int i); return (i != 0) ? 12 : 16; endfunction
  function automatic int ow(input int i); return (i != 0) ? 3 : 1;  endfunction

  logic [15:0] act [2];
  logic [15:0] shd [2];
  int          cnt [2];
  bit          ld  [2];
  logic [2:0]  ey  [2];
  bit          eyv [2], ebusy [2], edone [2], erb [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = (i != 0) ? 16'h0000 : 16'h0510;
        shd[i] = '0; cnt[i] = 0; ld[i] = 1'b0;
        ey[i] = '0; eyv[i] = 1'b0; edone[i] = 1'b0; erb[i] = 1'b0;
      end else begin
        edone[i] = 1'b0; eyv[i] = 1'b0; erb[i] = 1'b0;
        if (!ld[i]) begin
          if (xv[i]) begin
            ey[i]  = 3'((act[i] >> (int'(x[i]) * ow(i))) & ((1 << ow(i)) - 1));
            eyv[i] = 1'b1;
          end
          if (cs[i]) begin ld[i] = 1'b1; cnt[i] = 0; shd[i] = '0; end
        end else if (cs[i]) begin
          cnt[i] = 0; shd[i] = '0;
        end else if (cv[i]) begin
          erb[i] = act[i][cnt[i]];
          shd[i][cnt[i]] = cb[i];
          cnt[i]++;
          if (cnt[i] == nb(i)) begin act[i] = shd[i]; ld[i] = 1'b0; edone[i] = 1'b1; end
        end
      end
      ebusy[i] = ld[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("y_a", {31'b0, ya}, {29'b0, ey[0]});
      chk("y_b", {29'b0, yb}, {29'b0, ey[1]});
      for (int i = 0; i < 2; i++) begin
        chk("y_valid", {31'b0, yv[i]},   {31'b0, eyv[i]});
        chk("busy",    {31'b0, busy[i]}, {31'b0, ebusy[i]});
        chk("done",    {31'b0, done[i]}, {31'b0, edone[i]});
`ifdef LUT_READBACK_EN
        chk("rb",      {31'b0, rb[i]},   {31'b0, erb[i]});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      x[i] = '0; xv[i] = 1'b0; cs[i] = 1'b0; cb[i] = 1'b0; cv[i] = 1'b0;
    end
  endtask

  function automatic logic [3:0] rx(input int i);
    return (i != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
  endfunction

  task automatic sweep_a(input logic [15:0] tbl);
    for (int k = 0; k < 16; k++) begin
      x[0] = 4'(k); xv[0] = 1'b1;
      @(negedge clk);
      chk("sweep_y", {31'b0, ya}, {31'b0, tbl[k]});
      chk("sweep_v", {31'b0, yv_a}, 32'd1);
      #1;
    end
    xv[0] = 1'b0;
  endtask

  task automatic load(input int i, input logic [15:0] val, input int n, input bit fin,
                      output logic [15:0] rbv);
    rbv = '0;
    cs[i] = 1'b1; cv[i] = 1'($urandom); cb[i] = 1'b1; xv[i] = 1'b0;
    @(negedge clk); #1;
    cs[i] = 1'b0;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 2)) begin
        cv[i] = 1'b0; cb[i] = 1'($urandom); xv[i] = 1'($urandom); x[i] = rx(i);
        @(negedge clk);
        chk("ld_busy", {31'b0, busy[i]}, 32'd1);
        chk("ld_yv",   {31'b0, yv[i]},   32'd0);
        #1;
      end
      cv[i] = 1'b1; cb[i] = val[b]; xv[i] = 1'($urandom); x[i] = rx(i);
      @(negedge clk);
      rbv[b] = rb[i];
      if (fin && b == n - 1) chk("ld_done", {31'b0, done[i]}, 32'd1);
      else                   chk("ld_busy", {31'b0, busy[i]}, 32'd1);
      #1;
      cv[i] = 1'b0; xv[i] = 1'b0; x[i] = '0;
    end
  endtask

  initial begin
    logic [15:0] r;
    int e5 [4];
    e5 = '{4, 5, 6, 7};
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("rst_y_a", {31'b0, ya}, 32'd0);
    chk("rst_yv",  {31'b0, yv_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    #1 rst = 1'b0;

    sweep_a(16'h0510);                       // bits 4, 8, 10 set
    load(0, 16'hFFFF, 16, 1'b1, r);
    sweep_a(16'hFFFF);
    load(0, 16'h007F, 7, 1'b0, r);           // aborted by the restart below
    load(0, 16'h8001, 16, 1'b1, r);
    sweep_a(16'h8001);

    load(0, 16'hFFFF, 9, 1'b0, r);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy_a}, 32'd0);
    chk("midrst_done", {31'b0, done_a}, 32'd0);
    #1 rst = 1'b0;
    sweep_a(16'h0510);

`ifdef LUT_READBACK_EN
    load(0, 16'h0000, 16, 1'b1, r);
    chk("readback", {16'b0, r}, 32'h0510);
    sweep_a(16'h0000);
`endif

    load(1, 16'h0FAC, 12, 1'b1, r);
    for (int k = 0; k < 4; k++) begin
      x[1] = 4'(k); xv[1] = 1'b1;
      @(negedge clk);
      chk("wide_y", {29'b0, yb}, e5[k]);
      #1;
    end
    idle();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 400) == 0);
      for (int i = 0; i < 2; i++) begin
        xv[i] = 1'($urandom); x[i] = rx(i);
        cs[i] = ($urandom_range(0, 30) == 0);
        cv[i] = 1'($urandom); cb[i] = 1'($urandom);
      end
      @(negedge clk); #1;
    end
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
